// File: rtl/operand_fetch_if.sv
// Bundles the instruction, write-back and execute-side handshakes of the operand fetch stage.
// The DUT takes the slave modport and the driving environment takes the master modport.
interface operand_fetch_if #(
    parameter int WIDTH = 19
);
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic             wb_en;
    logic [2:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             ex_valid;
    logic             ex_ready;
    logic [WIDTH-1:0] ex_a;
    logic [WIDTH-1:0] ex_b;
    logic [2:0]       ex_alu_op;
    logic [2:0]       ex_rd;

    modport slave (
        input  instr_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
        output instr_ready, ex_valid, ex_a, ex_b, ex_alu_op, ex_rd
    );

    modport master (
        output instr_valid, instr, wb_en, wb_addr, wb_data, ex_ready,
        input  instr_ready, ex_valid, ex_a, ex_b, ex_alu_op, ex_rd
    );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch stage: decodes the instruction, reads the register file with write-back bypass,
// tracks pending destinations in a busy scoreboard and registers one operand bundle for the ALU.
module operand_fetch #(
    parameter int WIDTH = 19
) (
    input logic           clk,
    input logic           rst,
    operand_fetch_if.slave bus
);
    logic [WIDTH-1:0] r_regFile [0:7];
    logic [7:0]       r_busy;
    logic             r_exValid;
    logic [WIDTH-1:0] r_exA;
    logic [WIDTH-1:0] r_exB;
    logic [2:0]       r_exAluOp;
    logic [2:0]       r_exRd;

    logic [2:0]       w_aluOp;
    logic [2:0]       w_rd;
    logic [2:0]       w_rs1;
    logic [2:0]       w_rs2;
    logic             w_immSel;
    logic [5:0]       w_imm6;
    logic [WIDTH-1:0] w_immExt;
    logic [WIDTH-1:0] w_rs1Data;
    logic [WIDTH-1:0] w_rs2Data;
    logic [WIDTH-1:0] w_opB;
    logic [7:0]       w_wbClear;
    logic [7:0]       w_busySet;
    logic [7:0]       w_busyEff;
    logic             w_hazard;
    logic             w_accept;

    assign w_aluOp  = bus.instr[18:16];
    assign w_rd     = bus.instr[15:13];
    assign w_rs1    = bus.instr[12:10];
    assign w_rs2    = bus.instr[9:7];
    assign w_immSel = bus.instr[6];
    assign w_imm6   = bus.instr[5:0];
    assign w_immExt = {{(WIDTH-6){w_imm6[5]}}, w_imm6};

    // Source reads: r0 is hard zero, and a same-cycle write-back wins over the stored value.
    always_comb begin
        w_rs1Data = r_regFile[w_rs1];
        if (w_rs1 == 3'd0) begin
            w_rs1Data = '0;
        end else if (bus.wb_en && (bus.wb_addr == w_rs1)) begin
            w_rs1Data = bus.wb_data;
        end
        w_rs2Data = r_regFile[w_rs2];
        if (w_rs2 == 3'd0) begin
            w_rs2Data = '0;
        end else if (bus.wb_en && (bus.wb_addr == w_rs2)) begin
            w_rs2Data = bus.wb_data;
        end
    end

    assign w_opB = w_immSel ? w_immExt : w_rs2Data;

    always_comb begin
        w_wbClear = '0;
        if (bus.wb_en) begin
            w_wbClear[bus.wb_addr] = 1'b1;
        end
        w_busySet = '0;
        if (w_accept && (w_rd != 3'd0)) begin
            w_busySet[w_rd] = 1'b1;
        end
    end

    // A register being written back this cycle is already free for the hazard check.
    assign w_busyEff = r_busy & ~w_wbClear;
    assign w_hazard  = w_busyEff[w_rs1] | (w_busyEff[w_rs2] & ~w_immSel) | w_busyEff[w_rd];

    assign bus.instr_ready = !rst && (!r_exValid || bus.ex_ready) && !w_hazard;
    assign w_accept        = bus.instr_valid && bus.instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regFile[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_addr != 3'd0)) begin
            r_regFile[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Set is applied after clear so a same-cycle issue to the written register stays busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_wbClear) | w_busySet) & 8'hFE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exValid <= 1'b0;
            r_exA     <= '0;
            r_exB     <= '0;
            r_exAluOp <= 3'd0;
            r_exRd    <= 3'd0;
        end else if (w_accept) begin
            r_exValid <= 1'b1;
            r_exA     <= w_rs1Data;
            r_exB     <= w_opB;
            r_exAluOp <= w_aluOp;
            r_exRd    <= w_rd;
        end else if (bus.ex_ready) begin
            r_exValid <= 1'b0;
        end
    end

    assign bus.ex_valid  = r_exValid;
    assign bus.ex_a      = r_exA;
    assign bus.ex_b      = r_exB;
    assign bus.ex_alu_op = r_exAluOp;
    assign bus.ex_rd     = r_exRd;
endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter: WIDTH, 19, datapath and instruction width; all values below assume 19.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 instr_valid  input  1  upstream presents an instruction.
REQ-005 instr_ready  output  1  block accepts the instruction this cycle.
REQ-006 instr  input  19  instruction word: [18:16] alu_op, [15:13] rd, [12:10] rs1, [9:7] rs2, [6] imm_sel, [5:0] imm6.
REQ-007 wb_en  input  1  write-back strobe from the downstream stage.
REQ-008 wb_addr  input  3  write-back register index.
REQ-009 wb_data  input  19  write-back value (the ALU result).
REQ-010 ex_valid  output  1  operand bundle valid toward the ALU stage.
REQ-011 ex_ready  input  1  ALU stage consumes the bundle this cycle.
REQ-012 ex_a  output  19  operand A (ALU a).
REQ-013 ex_b  output  19  operand B (ALU b).
REQ-014 ex_alu_op  output  3  opcode passed unchanged to the ALU (000 ADD through 111 NOT).
REQ-015 ex_rd  output  3  destination register index carried to write-back.

Function
REQ-016 Register file: 8 x 19-bit registers r0..r7; r0 SHALL read as 0 and ignore writes.
REQ-017 On a cycle with wb_en=1 and wb_addr!=0, register[wb_addr] SHALL take wb_data at the clock edge.
REQ-018 Read bypass: if wb_en=1 and wb_addr equals a nonzero source index in the same cycle, that operand SHALL be wb_data rather than the stored value.
REQ-019 Operand A SHALL be register[rs1]; operand B SHALL be register[rs2] when imm_sel=0, else imm6 sign-extended from bit 5 to 19 bits.
REQ-020 Busy scoreboard: 8-bit mask; bit 0 SHALL always be 0.
REQ-021 Hazard: an instruction is blocked if busy[rs1] is set, or busy[rs2] is set with imm_sel=0, or busy[rd] is set (WAW).
REQ-022 A busy bit cleared by wb_en/wb_addr in the same cycle SHALL count as not busy for the hazard check.
REQ-023 instr_ready SHALL be (!ex_valid || ex_ready) && !hazard, evaluated combinationally.
REQ-024 Accept (instr_valid && instr_ready): the decoded operands, alu_op and rd SHALL be latched into the output register, ex_valid=1 next cycle, and busy[rd] set if rd!=0.
REQ-025 If the same register is both set by accept and cleared by write-back in one cycle, set SHALL win.
REQ-026 No accept and ex_ready=1: ex_valid SHALL go 0 next cycle; ex_* data may hold its old values.
REQ-027 Stall: while ex_valid=1 and ex_ready=0, every ex_* output SHALL hold stable.
REQ-028 Latency: 1 cycle from accept to ex_valid; throughput 1 instruction/cycle with no hazards.
REQ-029 A write-back to a register that is not busy SHALL still update the register file and leave the mask unchanged.
REQ-030 NOT (111) SHALL be forwarded like any other opcode; operand B is still produced.

Reset
REQ-031 While rst=1 at an edge: r1..r7=0, busy mask=0, ex_valid=0, ex_a=ex_b=0, ex_alu_op=000, ex_rd=000.
REQ-032 rst SHALL override any accept or write-back in the same cycle; in-flight bundles are discarded.
REQ-033 instr_ready SHALL be 0 while rst=1.

Verification
REQ-034 Reset, then wb r1=5, r2=3; issue ADD rd=3 rs1=1 rs2=2 -> next cycle ex_valid=1, ex_a=5, ex_b=3, ex_alu_op=000, ex_rd=3, busy[3]=1.
REQ-035 Issue SUB rd=4 rs1=1 imm_sel=1 imm6=6'h3F -> ex_b=19'h7FFFF; issue using rs1=0 -> ex_a=0, even after a wb to r0 of 19'h00007.
REQ-036 Issue ADD rd=3, then an instruction reading rs1=3 -> instr_ready=0 until wb_en with wb_addr=3, wb_data=8; in that cycle ready=1 and ex_a=8 (bypass).
REQ-037 Hold ex_ready=0 for 3 cycles with instr_valid=1 -> ex_* stable, instr_ready=0; release -> back-to-back accepts, one per cycle.
REQ-038 Same-cycle wb_addr=5 and accept of rd=5 -> busy[5]=1 afterwards and register r5 holds wb_data.
REQ-039 Assert rst mid-stall with ex_valid=1 and busy=8'h0E -> next cycle ex_valid=0, busy=0, reads of r1..r7 return 0.
